ibex_fetch_sequencer: RTL and testbench
=======================================

IBEX_FETCH_SEQUENCER -- requirements
Module: ibex_fetch_sequencer

Interface
REQ-001 SHALL have parameter NUM_REQS, default 2, giving the maximum number of outstanding bus requests (range 1-4).
REQ-002 SHALL have ports `clk_i`, input, 1 bit: the single clock.
REQ-003 SHALL have port `rst_i`, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have the following ports:
- `req_i`, input, 1 bit: fetch enable.
- `branch_i`, input, 1 bit: redirect pulse.
- `branch_addr_i`, input, 32 bits: redirect target, halfword aligned.
- `fifo_busy_i`, input, NUM_REQS bits: fetch FIFO upper-entry occupancy.
- `fifo_clear_o`, output, 1 bit: FIFO clear.
- `fifo_addr_o`, output, 32 bits: FIFO restart address.
- `fifo_valid_o`, output, 1 bit: FIFO push.
- `fifo_rdata_o`, output, 32 bits: push data.
- `fifo_err_o`, output, 1 bit: push error.
- `instr_req_o`, output, 1 bit: bus request.
- `instr_gnt_i`, input, 1 bit: bus grant.
- `instr_addr_o`, output, 32 bits: bus word address.
- `instr_rvalid_i`, input, 1 bit: response valid.
- `instr_rdata_i`, input, 32 bits: response data.
- `instr_err_i`, input, 1 bit: response error.
- `busy_o`, output, 1 bit: requests in flight.

Function
REQ-005 SHALL implement two states:
- IDLE: no un-granted request.
- WAIT_GNT: request presented, not yet granted.
REQ-006 SHALL keep `fetch_addr_q[31:2]`, the word address of the next request.
- On `branch_i`: load `branch_addr_i[31:2]`.
- On grant: increment by 1, wrapping from 0x3FFFFFFF to 0.
- Branch takes priority over grant.
REQ-007 SHALL drive `instr_addr_o` as {addr, 2'b00}:
- In IDLE: the branch target if `branch_i`=1, else `fetch_addr_q`.
- In WAIT_GNT: the held address of the pending request.
REQ-008 SHALL compute `can_issue` = `req_i` and (`outstanding_cnt` + popcount(`fifo_busy_i`) < NUM_REQS, or `branch_i`=1) and `outstanding_cnt` < NUM_REQS.
REQ-009 In IDLE, SHALL assert `instr_req_o` = `can_issue` combinationally.
- `instr_gnt_i`=1 in the same cycle: grant taken, remain IDLE.
- `instr_gnt_i`=0: go to WAIT_GNT.
REQ-010 In WAIT_GNT, SHALL hold `instr_req_o`=1 and `instr_addr_o` stable until `instr_gnt_i`=1, then return to IDLE.
- This holds regardless of `req_i` and `branch_i`.
REQ-011 A `branch_i` while in WAIT_GNT SHALL mark the pending request "discard" and SHALL NOT change `instr_addr_o`.
- The pending request is granted and completes normally, except that its response is discarded.
- The branch target is issued afterwards.
REQ-012 SHALL track outstanding granted requests in an in-order NUM_REQS-deep discard-flag shift register plus `outstanding_cnt`.
- `outstanding_cnt` is clog2(NUM_REQS+1) bits wide.
- Grant increments the count; `instr_rvalid_i` decrements it.
- Simultaneous grant and rvalid leave the count unchanged.
REQ-013 On `branch_i`, SHALL set the discard flag of every request outstanding in that cycle, including any request being granted in that same cycle.
- Exception: a request issued to the branch target from IDLE in that cycle is not flagged.
REQ-014 On `instr_rvalid_i`, the oldest entry SHALL be popped.
- `fifo_valid_o` = rvalid AND not discard AND not `branch_i`.
- `fifo_rdata_o` = `instr_rdata_i`, `fifo_err_o` = `instr_err_i`, combinational, zero latency.
REQ-015 SHALL assert `fifo_clear_o` = `branch_i` and `fifo_addr_o` = `branch_addr_i`, combinationally in the same cycle.
REQ-016 SHALL drive `busy_o` = (`outstanding_cnt` != 0) or (state == WAIT_GNT).
REQ-017 `instr_rvalid_i` with `outstanding_cnt`=0 is illegal; the block SHALL ignore it.
- Count does not underflow, and `fifo_valid_o`=0.
REQ-018 Deasserting `req_i` SHALL stop new requests only.
- Pending and outstanding requests complete.
- Their non-discarded responses are still pushed.

Reset
REQ-019 While `rst_i`=1 (asynchronously):
- state=IDLE, `fetch_addr_q`=0, `outstanding_cnt`=0, all discard flags=0.
- `instr_req_o`=0, `fifo_valid_o`=0, `fifo_clear_o`=0, `busy_o`=0.
REQ-020 Reset asserted mid-transaction SHALL abandon all tracking.
- Responses arriving after reset release fall under REQ-017.

Verification
REQ-021 Scenario: reset release, `branch_i`+`branch_addr_i`=0x0000_1002, `req_i`=1, gnt always 1, rvalid one cycle after each gnt.
- `fifo_clear_o` pulses with `fifo_addr_o`=0x1002.
- `instr_addr_o` sequence: 0x1000, 0x1004, 0x1008.
- Each response pushed.
REQ-022 Scenario: NUM_REQS=2, gnt=1, no rvalid.
- Exactly 2 requests issued, then `instr_req_o`=0.
- `busy_o`=1.
- One rvalid re-enables exactly one further request.
REQ-023 Scenario: `fifo_busy_i`=2'b01 with `outstanding_cnt`=1.
- `instr_req_o`=0.
- Same cycle with `branch_i`=1 (count 1 < 2): request issued to the branch target.
REQ-024 Scenario: gnt held 0 for 3 cycles, `branch_i` pulse in cycle 2 to 0x2000.
- `instr_addr_o` stays the old address until gnt.
- That response is not pushed.
- Next request addr = 0x2000.
REQ-025 Scenario: 2 outstanding, `branch_i` pulse, then 2 rvalids with `instr_err_i`=1.
- `fifo_valid_o` stays 0.
- `outstanding_cnt` returns to 0.
- First post-branch response pushed with its err value.
REQ-026 Scenario: `fetch_addr_q`=0xFFFF_FFFC granted.
- Next `instr_addr_o`=0x0000_0000.

Source files
------------

// File: rtl/ibex_fetch_sequencer.sv
// Instruction-fetch request sequencer: issues word fetches, tracks up to NUM_REQS
// outstanding bus requests and drops responses made stale by a redirect.
module ibex_fetch_sequencer #(
    parameter int NUM_REQS = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                req_i,
    input  logic                branch_i,
    input  logic [31:0]         branch_addr_i,
    input  logic [NUM_REQS-1:0] fifo_busy_i,

    output logic                fifo_clear_o,
    output logic [31:0]         fifo_addr_o,
    output logic                fifo_valid_o,
    output logic [31:0]         fifo_rdata_o,
    output logic                fifo_err_o,

    output logic                instr_req_o,
    input  logic                instr_gnt_i,
    output logic [31:0]         instr_addr_o,
    input  logic                instr_rvalid_i,
    input  logic [31:0]         instr_rdata_i,
    input  logic                instr_err_i,

    output logic                busy_o
);

    localparam int CNT_W = $clog2(NUM_REQS + 1);
    localparam logic [3:0] NUM_REQS_C = 4'(NUM_REQS);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] WAIT_GNT = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [29:0]         fetch_addr_q, fetch_addr_d;
    logic [29:0]         pend_addr_q;
    logic                pend_discard_q, pend_discard_d;
    logic [NUM_REQS-1:0] discard_q, discard_d;
    logic [CNT_W-1:0]    outstanding_cnt, cnt_d;
    logic [CNT_W-1:0]    live_cnt;

    logic                can_issue;
    logic                req_int;
    logic [29:0]         addr_int;
    logic                gnt_taken;
    logic                gnt_discard;
    logic                rvalid_ok;
    logic [3:0]          cnt_ext;

    function automatic logic [3:0] popcount(input logic [NUM_REQS-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < NUM_REQS; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    assign cnt_ext = 4'(outstanding_cnt);

    // A redirect may claim a slot even when the FIFO looks full, since the FIFO is about to be cleared.
    assign can_issue = req_i
                     && (((cnt_ext + popcount(fifo_busy_i)) < NUM_REQS_C) || branch_i)
                     && (cnt_ext < NUM_REQS_C);

    always_comb begin
        req_int  = 1'b0;
        addr_int = fetch_addr_q;
        if (state_q == WAIT_GNT) begin
            req_int  = 1'b1;
            addr_int = pend_addr_q;
        end else begin
            req_int  = can_issue;
            addr_int = branch_i ? branch_addr_i[31:2] : fetch_addr_q;
        end
    end

    assign instr_req_o  = req_int && !rst_i;
    assign instr_addr_o = {addr_int, 2'b00};

    assign gnt_taken   = instr_req_o && instr_gnt_i;
    assign gnt_discard = (state_q == WAIT_GNT) && (pend_discard_q || branch_i);
    assign rvalid_ok   = instr_rvalid_i && (outstanding_cnt != '0) && !rst_i;

    // Discard flags are kept oldest-first at index 0; pop, then flag on redirect, then append.
    always_comb begin
        discard_d = discard_q;
        live_cnt  = outstanding_cnt;
        if (rvalid_ok) begin
            discard_d = discard_q >> 1;
            live_cnt  = outstanding_cnt - CNT_W'(1);
        end
        if (branch_i) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (CNT_W'(i) < live_cnt) begin
                    discard_d[i] = 1'b1;
                end
            end
        end
        if (gnt_taken) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (CNT_W'(i) == live_cnt) begin
                    discard_d[i] = gnt_discard;
                end
            end
        end
        cnt_d = live_cnt + CNT_W'(gnt_taken);
    end

    always_comb begin
        state_d        = state_q;
        pend_discard_d = pend_discard_q;
        case (state_q)
            IDLE: begin
                if (instr_req_o && !instr_gnt_i) begin
                    state_d        = WAIT_GNT;
                    pend_discard_d = 1'b0;
                end
            end
            WAIT_GNT: begin
                if (instr_gnt_i) begin
                    state_d        = IDLE;
                    pend_discard_d = 1'b0;
                end else if (branch_i) begin
                    pend_discard_d = 1'b1;
                end
            end
            default: begin
                state_d        = IDLE;
                pend_discard_d = 1'b0;
            end
        endcase
    end

    // A granted live request advances past its own address, so a redirect issued straight
    // from IDLE continues at target+1; a stale grant leaves the redirect target in place.
    always_comb begin
        fetch_addr_d = fetch_addr_q;
        if (branch_i) begin
            fetch_addr_d = branch_addr_i[31:2];
        end
        if (gnt_taken && !gnt_discard) begin
            fetch_addr_d = addr_int + 30'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            fetch_addr_q    <= '0;
            pend_discard_q  <= 1'b0;
            discard_q       <= '0;
            outstanding_cnt <= '0;
        end else begin
            state_q         <= state_d;
            fetch_addr_q    <= fetch_addr_d;
            pend_discard_q  <= pend_discard_d;
            discard_q       <= discard_d;
            outstanding_cnt <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if ((state_q == IDLE) && instr_req_o && !instr_gnt_i) begin
            pend_addr_q <= addr_int;
        end
    end

    assign fifo_clear_o = branch_i && !rst_i;
    assign fifo_addr_o  = branch_addr_i;
    assign fifo_valid_o = rvalid_ok && !discard_q[0] && !branch_i;
    assign fifo_rdata_o = instr_rdata_i;
    assign fifo_err_o   = instr_err_i;

    assign busy_o = !rst_i && ((outstanding_cnt != '0) || (state_q == WAIT_GNT));

endmodule

// File: tb/tb_ibex_fetch_sequencer.sv
// Directed bench for ibex_fetch_sequencer with a queue-based reference model.
module tb_ibex_fetch_sequencer;

    localparam int N = 2;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          req_i, branch_i;
    logic [31:0]   branch_addr_i;
    logic [N-1:0]  fifo_busy_i;
    logic          fifo_clear_o, fifo_valid_o, fifo_err_o;
    logic [31:0]   fifo_addr_o, fifo_rdata_o;
    logic          instr_req_o, instr_gnt_i, instr_rvalid_i, instr_err_i;
    logic [31:0]   instr_addr_o, instr_rdata_i;
    logic          busy_o;

    int n_tests = 0;
    int n_fail  = 0;
    int ngr;

    ibex_fetch_sequencer #(.NUM_REQS(N)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_i(req_i), .branch_i(branch_i), .branch_addr_i(branch_addr_i),
        .fifo_busy_i(fifo_busy_i),
        .fifo_clear_o(fifo_clear_o), .fifo_addr_o(fifo_addr_o),
        .fifo_valid_o(fifo_valid_o), .fifo_rdata_o(fifo_rdata_o), .fifo_err_o(fifo_err_o),
        .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i), .instr_addr_o(instr_addr_o),
        .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding requests as a queue of stale flags, plus one pending request.
    bit          mq[$];
    bit          m_pend;
    bit          m_pdisc;
    logic [29:0] m_paddr;
    logic [29:0] m_next;
    int          cnt;
    bit          e_req, e_pop, e_valid, granted, gflag;
    logic [29:0] e_waddr;

    always @(negedge clk_i) begin
        if (rst_i) begin
            chk("rst_req",   32'(instr_req_o),  32'd0);
            chk("rst_valid", 32'(fifo_valid_o), 32'd0);
            chk("rst_clear", 32'(fifo_clear_o), 32'd0);
            chk("rst_busy",  32'(busy_o),       32'd0);
            mq.delete();
            m_pend  = 1'b0;
            m_pdisc = 1'b0;
            m_next  = '0;
        end else begin
            cnt = mq.size();
            if (m_pend) begin
                e_req   = 1'b1;
                e_waddr = m_paddr;
            end else begin
                e_req   = req_i && (((cnt + $countones(fifo_busy_i)) < N) || branch_i) && (cnt < N);
                e_waddr = branch_i ? branch_addr_i[31:2] : m_next;
            end
            chk("req",   32'(instr_req_o),  32'(e_req));
            chk("addr",  instr_addr_o,      {e_waddr, 2'b00});
            chk("clear", 32'(fifo_clear_o), 32'(branch_i));
            chk("faddr", fifo_addr_o,       branch_addr_i);
            e_pop   = instr_rvalid_i && (cnt > 0);
            e_valid = 1'b0;
            if (e_pop) e_valid = !mq[0] && !branch_i;
            chk("valid", 32'(fifo_valid_o), 32'(e_valid));
            if (e_valid) begin
                chk("rdata", fifo_rdata_o,     instr_rdata_i);
                chk("err",   32'(fifo_err_o),  32'(instr_err_i));
            end
            chk("busy", 32'(busy_o), 32'((cnt > 0) || m_pend));

            granted = e_req && instr_gnt_i;
            gflag   = m_pend ? (m_pdisc || branch_i) : 1'b0;
            if (e_pop) void'(mq.pop_front());
            if (branch_i) foreach (mq[i]) mq[i] = 1'b1;
            if (granted) mq.push_back(gflag);
            if (branch_i) m_next = branch_addr_i[31:2];
            if (granted && !gflag) m_next = e_waddr + 30'd1;
            if (m_pend) begin
                if (instr_gnt_i) m_pend = 1'b0;
                else if (branch_i) m_pdisc = 1'b1;
            end else if (e_req && !instr_gnt_i) begin
                m_pend  = 1'b1;
                m_paddr = e_waddr;
                m_pdisc = 1'b0;
            end
        end
    end

    task automatic cyc(input logic rs, input logic rq, input logic br, input logic [31:0] ba,
                       input logic [N-1:0] fb, input logic gn, input logic rv,
                       input logic [31:0] rd, input logic er);
        @(posedge clk_i);
        #1;
        rst_i          = rs;
        req_i          = rq;
        branch_i       = br;
        branch_addr_i  = ba;
        fifo_busy_i    = fb;
        instr_gnt_i    = gn;
        instr_rvalid_i = rv;
        instr_rdata_i  = rd;
        instr_err_i    = er;
        #2;
    endtask

    initial begin
        rst_i = 1'b1; req_i = 1'b1; branch_i = 1'b1; branch_addr_i = 32'h1002;
        fifo_busy_i = '0; instr_gnt_i = 1'b1; instr_rvalid_i = 1'b1;
        instr_rdata_i = 32'hAAAA_AAAA; instr_err_i = 1'b1;

        // reset holds all control outputs low even with active inputs
        repeat (2) cyc(1, 1, 1, 32'h1002, '0, 1, 1, 32'hAAAA_AAAA, 1);
        chk("lit_rst_req",   32'(instr_req_o),  32'd0);
        chk("lit_rst_busy",  32'(busy_o),       32'd0);
        chk("lit_rst_clear", 32'(fifo_clear_o), 32'd0);
        chk("lit_rst_valid", 32'(fifo_valid_o), 32'd0);

        // redirect at reset release, streaming fetch
        cyc(0, 1, 1, 32'h1002, '0, 1, 0, 32'h0, 0);
        chk("lit_a_clear", 32'(fifo_clear_o), 32'd1);
        chk("lit_a_faddr", fifo_addr_o, 32'h0000_1002);
        chk("lit_a_addr0", instr_addr_o, 32'h0000_1000);
        cyc(0, 1, 0, 32'h0, '0, 1, 1, 32'hA0A0_0001, 0);
        chk("lit_a_addr1", instr_addr_o, 32'h0000_1004);
        chk("lit_a_push1", 32'(fifo_valid_o), 32'd1);
        cyc(0, 1, 0, 32'h0, '0, 1, 1, 32'hA0A0_0002, 0);
        chk("lit_a_addr2", instr_addr_o, 32'h0000_1008);
        chk("lit_a_push2", 32'(fifo_valid_o), 32'd1);
        cyc(0, 0, 0, 32'h0, '0, 0, 1, 32'hA0A0_0003, 0);
        chk("lit_a_push3", 32'(fifo_valid_o), 32'd1);
        cyc(0, 0, 0, 32'h0, '0, 0, 0, 32'h0, 0);

        // outstanding limit
        ngr = 0;
        repeat (4) begin
            cyc(0, 1, 0, 32'h0, '0, 1, 0, 32'h0, 0);
            if (instr_req_o) ngr++;
        end
        chk("lit_b_grants", ngr, 32'd2);
        chk("lit_b_busy", 32'(busy_o), 32'd1);
        ngr = 0;
        cyc(0, 1, 0, 32'h0, '0, 1, 1, 32'hB0B0_0001, 0);
        if (instr_req_o) ngr++;
        repeat (3) begin
            cyc(0, 1, 0, 32'h0, '0, 1, 0, 32'h0, 0);
            if (instr_req_o) ngr++;
        end
        chk("lit_b_regrant", ngr, 32'd1);
        repeat (2) cyc(0, 0, 0, 32'h0, '0, 0, 1, 32'hB0B0_0002, 0);

        // FIFO occupancy throttling, overridden by a redirect
        cyc(0, 1, 0, 32'h0, 2'b00, 1, 0, 32'h0, 0);
        cyc(0, 1, 0, 32'h0, 2'b01, 1, 0, 32'h0, 0);
        chk("lit_c_throttle", 32'(instr_req_o), 32'd0);
        cyc(0, 1, 1, 32'h3000, 2'b01, 1, 0, 32'h0, 0);
        chk("lit_c_req", 32'(instr_req_o), 32'd1);
        chk("lit_c_addr", instr_addr_o, 32'h0000_3000);
        cyc(0, 0, 0, 32'h0, 2'b00, 0, 1, 32'hC0C0_0001, 0);
        chk("lit_c_drop", 32'(fifo_valid_o), 32'd0);
        cyc(0, 0, 0, 32'h0, 2'b00, 0, 1, 32'hC0C0_0002, 0);
        chk("lit_c_push", 32'(fifo_valid_o), 32'd1);

        // redirect while waiting for grant
        cyc(0, 1, 0, 32'h0, '0, 0, 0, 32'h0, 0);
        chk("lit_d_addr1", instr_addr_o, 32'h0000_3004);
        cyc(0, 1, 1, 32'h2000, '0, 0, 0, 32'h0, 0);
        chk("lit_d_addr2", instr_addr_o, 32'h0000_3004);
        cyc(0, 0, 0, 32'h0, '0, 0, 0, 32'h0, 0);
        chk("lit_d_hold", 32'(instr_req_o), 32'd1);
        chk("lit_d_addr3", instr_addr_o, 32'h0000_3004);
        cyc(0, 0, 0, 32'h0, '0, 1, 0, 32'h0, 0);
        chk("lit_d_addr4", instr_addr_o, 32'h0000_3004);
        cyc(0, 1, 0, 32'h0, '0, 1, 1, 32'hD0D0_0001, 0);
        chk("lit_d_drop", 32'(fifo_valid_o), 32'd0);
        chk("lit_d_target", instr_addr_o, 32'h0000_2000);
        cyc(0, 0, 0, 32'h0, '0, 0, 1, 32'hD0D0_0002, 0);
        chk("lit_d_push", 32'(fifo_valid_o), 32'd1);

        // redirect with two outstanding, error responses
        repeat (2) cyc(0, 1, 0, 32'h0, '0, 1, 0, 32'h0, 0);
        cyc(0, 0, 1, 32'h4000, '0, 0, 0, 32'h0, 0);
        cyc(0, 0, 0, 32'h0, '0, 0, 1, 32'hE0E0_0001, 1);
        chk("lit_e_drop1", 32'(fifo_valid_o), 32'd0);
        cyc(0, 0, 0, 32'h0, '0, 0, 1, 32'hE0E0_0002, 1);
        chk("lit_e_drop2", 32'(fifo_valid_o), 32'd0);
        cyc(0, 1, 0, 32'h0, '0, 1, 0, 32'h0, 0);
        chk("lit_e_idle", 32'(busy_o), 32'd0);
        chk("lit_e_addr", instr_addr_o, 32'h0000_4000);
        cyc(0, 0, 0, 32'h0, '0, 0, 1, 32'hE0E0_0003, 1);
        chk("lit_e_push", 32'(fifo_valid_o), 32'd1);
        chk("lit_e_err", 32'(fifo_err_o), 32'd1);

        // address wrap and an unsolicited response
        cyc(0, 1, 1, 32'hFFFF_FFFC, '0, 1, 0, 32'h0, 0);
        chk("lit_f_top", instr_addr_o, 32'hFFFF_FFFC);
        cyc(0, 1, 0, 32'h0, '0, 1, 1, 32'hF0F0_0001, 0);
        chk("lit_f_wrap", instr_addr_o, 32'h0000_0000);
        cyc(0, 0, 0, 32'h0, '0, 0, 1, 32'hF0F0_0002, 0);
        cyc(0, 0, 0, 32'h0, '0, 0, 1, 32'hF0F0_0003, 0);
        chk("lit_f_spurious", 32'(fifo_valid_o), 32'd0);
        chk("lit_f_busy", 32'(busy_o), 32'd0);

        // reset in the middle of traffic
        repeat (2) cyc(0, 1, 0, 32'h0, '0, 1, 0, 32'h0, 0);
        cyc(1, 1, 0, 32'h0, '0, 1, 1, 32'h0, 0);
        chk("lit_g_busy", 32'(busy_o), 32'd0);
        cyc(0, 0, 0, 32'h0, '0, 0, 1, 32'h6060_0001, 0);
        chk("lit_g_stale", 32'(fifo_valid_o), 32'd0);
        cyc(0, 1, 0, 32'h0, '0, 1, 0, 32'h0, 0);
        chk("lit_g_addr", instr_addr_o, 32'h0000_0000);
        cyc(0, 0, 0, 32'h0, '0, 0, 1, 32'h6060_0002, 0);
        chk("lit_g_push", 32'(fifo_valid_o), 32'd1);
        cyc(0, 0, 0, 32'h0, '0, 0, 0, 32'h0, 0);

        @(posedge clk_i);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
